// File: rtl/instr_sequencer.sv
// instr_sequencer: steps a small program memory into the cpu instruction port.
// For each word: load it into the cpu instruction register, pulse s, then wait
// for w to fall and rise again before moving on.
// Optional build macro SEQ_TIMEOUT_EN adds a watchdog on the two wait states
// that aborts the run and raises a sticky err flag.
module instr_sequencer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              go,
    input  logic              cpu_w,
    output logic [15:0]       cpu_in,
    output logic              cpu_load,
    output logic              cpu_s,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // Reject configurations where the address does not exactly cover the memory.
    if (DEPTH != (1 << ADDR_W) || TIMEOUT_CYC == 0) begin : g_bad_cfg
        $error("instr_sequencer: DEPTH must equal 2**ADDR_W and TIMEOUT_CYC must be nonzero");
    end

    logic [15:0]       mem [DEPTH];
    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] last_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic [15:0]       cpu_in_nxt;
    logic [15:0]       first_word;
    logic              load_nxt;
    logic              s_nxt;
    logic              done_nxt;
    logic              tmo_hit;

    assign pc_inc = pc + ADDR_W'(1);

    // A write to slot 0 in the same cycle as go must be seen by the first LOAD.
    assign first_word = (prog_we && (prog_addr == '0)) ? prog_data : mem[0];

    // Program memory write; only while idle, contents survive reset.
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            last_q   <= '0;
            cpu_in   <= 16'h0000;
            cpu_load <= 1'b0;
            cpu_s    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            last_q   <= last_nxt;
            cpu_in   <= cpu_in_nxt;
            cpu_load <= load_nxt;
            cpu_s    <= s_nxt;
            done     <= done_nxt;
            busy     <= (state_nxt != S_IDLE);
        end
    end

    // Next-state and next-output decode; X/Z on cpu_w never satisfies a wait.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        last_nxt   = last_q;
        cpu_in_nxt = cpu_in;
        load_nxt   = 1'b0;
        s_nxt      = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (go && (cpu_w == 1'b1)) begin
                    state_nxt  = S_LOAD;
                    pc_nxt     = '0;
                    last_nxt   = last_addr;
                    cpu_in_nxt = first_word;
                    load_nxt   = 1'b1;
                end
            end
            S_LOAD: begin
                state_nxt = S_START;
                s_nxt     = 1'b1;
            end
            S_START: begin
                state_nxt = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (cpu_w == 1'b0) begin
                    state_nxt = S_WAIT_HI;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT_HI: begin
                if (cpu_w == 1'b1) begin
                    if (pc == last_q) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt  = S_LOAD;
                        pc_nxt     = pc_inc;
                        cpu_in_nxt = mem[pc_inc];
                        load_nxt   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             in_wait;
    logic             err_q;

    assign in_wait = (state == S_WAIT_LO) || (state == S_WAIT_HI);
    assign tmo_hit = in_wait && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign err     = err_q;

    // Cycles spent in the current wait state; restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if ((state_nxt != state) || !in_wait) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Sticky timeout flag, cleared when the next run is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((state == S_IDLE) && (state_nxt == S_LOAD)) begin
            err_q <= 1'b0;
        end else if (in_wait && (state_nxt == S_IDLE)) begin
            err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule
